// File: rtl/slave_in_port_pkg.sv
// Shared serial-bus definitions for the slave receive port.
//   - command encodings latched at the handshake
//   - receive FSM state encodings
//   - default address/data widths and small width helpers
package slave_in_port_pkg;

    localparam int DEFAULT_ADDR_LEN = 12;
    localparam int DEFAULT_DATA_LEN = 8;

    typedef enum logic [1:0] {
        INACTIVE = 2'b00,
        WRITE    = 2'b10,
        READ     = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        REQUEST,
        READ_WAIT
    } state_e;

    // Number of serial cycles per transfer: the longer of the two fields.
    function automatic int max_len(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width for a 0..l-1 range, never narrower than one bit.
    function automatic int cnt_width(input int l);
        return (l > 1) ? $clog2(l) : 1;
    endfunction

endpackage

// File: rtl/slave_in_port_serial_shift_in.sv
// Serial-to-parallel capture register, LSB-first by bit index.
// Ports:
//   clk, reset   bus clock, asynchronous active-high reset
//   en           write bit_in into position idx this cycle
//   bit_in       serial input bit
//   idx          bit position being received; positions >= W are ignored
//   data         parallel W-bit contents
module serial_shift_in #(
    parameter int W     = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             bit_in,
    input  logic [IDX_W-1:0] idx,
    output logic [W-1:0]     data
);

    // NOTE: every flop shares the asynchronous reset so a reset mid-transfer
    // discards the partial word in the same instant as the FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else begin
            // Compare against each position instead of indexing with idx, so
            // indices beyond the field width simply match nothing.
            for (int i = 0; i < W; i++) begin
                if (en && idx == IDX_W'(i)) begin
                    // NOTE: state registers update with non-blocking assignments
                    // so every flop samples the pre-edge values.
                    data[i] <= bit_in;
                end
            end
        end
    end

endmodule

// File: rtl/slave_in_port.sv
// Slave-side receive port of the serial system bus.
// Accepts the master's valid/ready handshake, deserialises rx_address and
// rx_data LSB-first over max(ADDR_LEN, DATA_LEN) cycles, then raises one
// write or read request to local memory. Reads block further transfers until
// the slave output port reports read_tx_done.
// Ports:
//   clk, reset          bus clock, asynchronous active-high reset
//   selected            address decoder hit for this slave
//   master_valid        master driving a transfer (must stay high while bits flow)
//   write_en, read_en   command, sampled only at the handshake
//   rx_address, rx_data serial address / write-data bits
//   core_ack            memory accepted the pending request
//   read_tx_done        read data has been returned to the master
//   slave_ready         ready for a new handshake
//   mem_address         received address
//   mem_wdata           received write data
//   write_req, read_req request to memory, held until core_ack
//   rx_done             one-cycle pulse when a word has been received
module slave_in_port
    import slave_in_port_pkg::*;
#(
    parameter int ADDR_LEN = DEFAULT_ADDR_LEN,
    parameter int DATA_LEN = DEFAULT_DATA_LEN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                selected,
    input  logic                master_valid,
    input  logic                write_en,
    input  logic                read_en,
    input  logic                rx_address,
    input  logic                rx_data,
    input  logic                core_ack,
    input  logic                read_tx_done,
    output logic                slave_ready,
    output logic [ADDR_LEN-1:0] mem_address,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                write_req,
    output logic                read_req,
    output logic                rx_done
);

    localparam int               L     = max_len(ADDR_LEN, DATA_LEN);
    localparam int               CNT_W = cnt_width(L);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(L - 1);

    state_e             state_q, state_d;
    cmd_e               cmd_q, cmd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_d, write_req_d, read_req_d, rx_done_d;
    logic               handshake, capture, finish, load;
    logic [ADDR_LEN-1:0] addr_shift, addr_word;
    logic [DATA_LEN-1:0] data_shift, data_word;

    assign handshake = selected & master_valid & slave_ready & (write_en ^ read_en);

    // Bit 0 is taken at the handshake edge itself, the rest while receiving.
    assign capture = (state_q == IDLE && handshake) ||
                     (state_q == RECEIVE && master_valid);

    serial_shift_in #(.W(ADDR_LEN), .IDX_W(CNT_W)) u_addr_shift (
        .clk    (clk),
        .reset  (reset),
        .en     (capture),
        .bit_in (rx_address),
        .idx    (count_q),
        .data   (addr_shift)
    );

    serial_shift_in #(.W(DATA_LEN), .IDX_W(CNT_W)) u_data_shift (
        .clk    (clk),
        .reset  (reset),
        .en     (capture),
        .bit_in (rx_data),
        .idx    (count_q),
        .data   (data_shift)
    );

    // The last bit lands in the shift register on the same edge that loads the
    // outputs, so splice the live line value into the word being published.
    always_comb begin
        addr_word = addr_shift;
        data_word = data_shift;
        for (int i = 0; i < ADDR_LEN; i++) begin
            if (count_q == CNT_W'(i)) addr_word[i] = rx_address;
        end
        for (int i = 0; i < DATA_LEN; i++) begin
            if (count_q == CNT_W'(i)) data_word[i] = rx_data;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d     = state_q;
        cmd_d       = cmd_q;
        count_d     = count_q;
        ready_d     = slave_ready;
        write_req_d = write_req;
        read_req_d  = read_req;
        rx_done_d   = 1'b0;
        finish      = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (handshake) begin
                    cmd_d   = read_en ? READ : WRITE;
                    ready_d = 1'b0;
                    if (L == 1) begin
                        finish = 1'b1;
                    end else begin
                        count_d = CNT_W'(1);
                        state_d = RECEIVE;
                    end
                end
            end
            RECEIVE: begin
                if (!master_valid) begin
                    // Master gave up: drop the partial word silently.
                    state_d = IDLE;
                    ready_d = 1'b1;
                    count_d = '0;
                end else if (count_q == LAST) begin
                    finish = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            REQUEST: begin
                if (core_ack) begin
                    write_req_d = 1'b0;
                    read_req_d  = 1'b0;
                    if (cmd_q == READ && !read_tx_done) begin
                        state_d = READ_WAIT;
                    end else begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end
                end
            end
            READ_WAIT: begin
                if (read_tx_done) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase

        if (finish) begin
            load        = 1'b1;
            rx_done_d   = 1'b1;
            write_req_d = (cmd_d == WRITE);
            read_req_d  = (cmd_d == READ);
            count_d     = '0;
            state_d     = REQUEST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= INACTIVE;
            count_q     <= '0;
            slave_ready <= 1'b1;
            write_req   <= 1'b0;
            read_req    <= 1'b0;
            rx_done     <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            count_q     <= count_d;
            slave_ready <= ready_d;
            write_req   <= write_req_d;
            read_req    <= read_req_d;
            rx_done     <= rx_done_d;
            if (load) begin
                mem_address <= addr_word;
                mem_wdata   <= data_word;
            end
        end
    end

endmodule
